// File: rtl/tx_sched_pkg.sv
// Shared types and constants for the transmit frame scheduler: state encoding,
// default framing bytes and the CRC-8 (poly 0x07, MSB first) byte step.
package tx_sched_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SOF,
        ST_HDR,
        ST_LEN,
        ST_PAYLOAD,
        ST_CHK,
        ST_ABORT,
        ST_PRBS
    } state_t;

    localparam logic [7:0] DEF_IDLE_BYTE  = 8'hBC;
    localparam logic [7:0] DEF_SOF_BYTE   = 8'hFB;
    localparam logic [7:0] DEF_ABORT_BYTE = 8'hFD;
    localparam logic [7:0] DEF_HDR_TAG    = 8'hA0;

    function automatic logic [7:0] crc8_step(input logic [7:0] crc_in, input logic [7:0] data);
        logic [7:0] c;
        c = crc_in ^ data;
        for (int i = 0; i < 8; i++) begin
            c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/tx_check8.sv
// Frame check accumulator: modular byte sum by default, CRC-8 (poly 0x07, init 0)
// when TX_SCHED_CRC8_EN is defined. Clear has priority over enable.
module tx_check8
    import tx_sched_pkg::*;
(
    input  logic       clk_bit,
    input  logic       rst,
    input  logic       clear,
    input  logic       enable,
    input  logic [7:0] byte_in,
    output logic [7:0] chk
);

    logic [7:0] chk_reg;
    logic [7:0] chk_next;

`ifdef TX_SCHED_CRC8_EN
    assign chk_next = crc8_step(chk_reg, byte_in);
`else
    assign chk_next = chk_reg + byte_in;
`endif

    always_ff @(posedge clk_bit or posedge rst) begin
        if (rst) begin
            chk_reg <= 8'h00;
        end else if (clear) begin
            chk_reg <= 8'h00;
        end else if (enable) begin
            chk_reg <= chk_next;
        end
    end

    assign chk = chk_reg;

endmodule

// File: rtl/tx_frame_scheduler.sv
// Feeds the 8b/10b transmitter one byte per word slot: round-robin between two
// byte sources, SOF/HDR/LEN/payload/CHK framing, IDLE fill and PRBS sequencing.
module tx_frame_scheduler
    import tx_sched_pkg::*;
#(
    parameter logic [7:0] IDLE_BYTE  = DEF_IDLE_BYTE,
    parameter logic [7:0] SOF_BYTE   = DEF_SOF_BYTE,
    parameter logic [7:0] ABORT_BYTE = DEF_ABORT_BYTE,
    parameter logic [7:0] HDR_TAG    = DEF_HDR_TAG
) (
    input  logic        clk_bit,
    input  logic        rst,
    input  logic        word_strobe,
    output logic [7:0]  tx_byte,
    output logic        prbs_on,
    input  logic        prbs_req,
    input  logic [1:0]  src_valid,
    input  logic [15:0] src_data,
    input  logic [15:0] src_len,
    output logic [1:0]  src_ready,
    output logic        busy,
    output logic        frame_done,
    output logic        underrun_err
);

    state_t     state_reg;
    logic [7:0] tx_byte_reg;
    logic [7:0] len_reg;
    logic [7:0] cnt_reg;
    logic       grant_reg;
    logic       rr_reg;
    logic       prbs_on_reg;
    logic       prbs_dly_reg;
    logic       frame_done_reg;
    logic       underrun_reg;

    logic       mask;
    logic       eff_strobe;
    logic       xfer_slot;
    logic       sel_valid;
    logic [7:0] sel_data;
    logic       idle_grant;
    logic [7:0] idle_len;
    logic       chk_clear;
    logic       chk_en;
    logic [7:0] chk_byte;
    logic [7:0] chk_value;

    // The transmitter's word strobe is unreliable while it runs PRBS and for the
    // cycle after it leaves, so strobes are ignored across that whole window.
    assign mask       = prbs_on_reg | prbs_dly_reg;
    assign eff_strobe = word_strobe & ~mask;

    assign xfer_slot  = eff_strobe &
                        ((state_reg == ST_LEN) || (state_reg == ST_PAYLOAD && cnt_reg != 8'd0));
    assign sel_valid  = grant_reg ? src_valid[1] : src_valid[0];
    assign sel_data   = grant_reg ? src_data[15:8] : src_data[7:0];

    // On a tie the channel that did not win last time is granted.
    assign idle_grant = (src_valid == 2'b11) ? ~rr_reg : src_valid[1];
    assign idle_len   = idle_grant ? src_len[15:8] : src_len[7:0];

    for (genvar gi = 0; gi < 2; gi++) begin : g_ready
        assign src_ready[gi] = xfer_slot & src_valid[gi] & (grant_reg == 1'(gi));
    end

    always_comb begin
        chk_byte = sel_data;
        chk_en   = 1'b0;
        if (eff_strobe) begin
            if (state_reg == ST_SOF) begin
                chk_byte = HDR_TAG | {7'b0, grant_reg};
                chk_en   = 1'b1;
            end else if (state_reg == ST_HDR) begin
                chk_byte = len_reg;
                chk_en   = 1'b1;
            end else if (xfer_slot && sel_valid) begin
                chk_en   = 1'b1;
            end
        end
    end

    assign chk_clear = eff_strobe && (state_reg == ST_CHK || state_reg == ST_ABORT);

    tx_check8 u_check (
        .clk_bit (clk_bit),
        .rst     (rst),
        .clear   (chk_clear),
        .enable  (chk_en),
        .byte_in (chk_byte),
        .chk     (chk_value)
    );

    always_ff @(posedge clk_bit or posedge rst) begin
        if (rst) begin
            state_reg      <= ST_IDLE;
            tx_byte_reg    <= IDLE_BYTE;
            len_reg        <= 8'h00;
            cnt_reg        <= 8'h00;
            grant_reg      <= 1'b0;
            rr_reg         <= 1'b1;
            prbs_on_reg    <= 1'b0;
            prbs_dly_reg   <= 1'b0;
            frame_done_reg <= 1'b0;
            underrun_reg   <= 1'b0;
        end else begin
            frame_done_reg <= 1'b0;
            underrun_reg   <= 1'b0;
            prbs_dly_reg   <= prbs_on_reg;
            // PRBS exit is not strobe-gated since strobes are masked throughout.
            if (state_reg == ST_PRBS) begin
                if (!prbs_req) begin
                    prbs_on_reg <= 1'b0;
                    tx_byte_reg <= IDLE_BYTE;
                    state_reg   <= ST_IDLE;
                end
            end else if (eff_strobe) begin
                case (state_reg)
                    ST_IDLE: begin
                        if (prbs_req) begin
                            prbs_on_reg <= 1'b1;
                            tx_byte_reg <= IDLE_BYTE;
                            state_reg   <= ST_PRBS;
                        end else if (|src_valid) begin
                            grant_reg   <= idle_grant;
                            rr_reg      <= idle_grant;
                            len_reg     <= idle_len;
                            cnt_reg     <= idle_len;
                            tx_byte_reg <= SOF_BYTE;
                            state_reg   <= ST_SOF;
                        end else begin
                            tx_byte_reg <= IDLE_BYTE;
                        end
                    end
                    ST_SOF: begin
                        tx_byte_reg <= HDR_TAG | {7'b0, grant_reg};
                        state_reg   <= ST_HDR;
                    end
                    ST_HDR: begin
                        tx_byte_reg <= len_reg;
                        state_reg   <= ST_LEN;
                    end
                    ST_LEN, ST_PAYLOAD: begin
                        if (state_reg == ST_PAYLOAD && cnt_reg == 8'd0) begin
                            tx_byte_reg <= chk_value;
                            state_reg   <= ST_CHK;
                        end else if (sel_valid) begin
                            tx_byte_reg <= sel_data;
                            state_reg   <= ST_PAYLOAD;
                            // The LEN-slot byte is the first of len+1, so it does not count down.
                            if (state_reg == ST_PAYLOAD) begin
                                cnt_reg <= cnt_reg - 8'd1;
                            end
                        end else begin
                            tx_byte_reg  <= ABORT_BYTE;
                            underrun_reg <= 1'b1;
                            state_reg    <= ST_ABORT;
                        end
                    end
                    ST_CHK: begin
                        tx_byte_reg    <= IDLE_BYTE;
                        frame_done_reg <= 1'b1;
                        state_reg      <= ST_IDLE;
                    end
                    ST_ABORT: begin
                        tx_byte_reg <= IDLE_BYTE;
                        state_reg   <= ST_IDLE;
                    end
                    default: begin
                        tx_byte_reg <= IDLE_BYTE;
                        state_reg   <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign tx_byte      = tx_byte_reg;
    assign prbs_on      = prbs_on_reg;
    assign busy         = (state_reg != ST_IDLE);
    assign frame_done   = frame_done_reg;
    assign underrun_err = underrun_reg;

endmodule
